// File: rtl/pulse_peak_detector_pkg.sv
// Shared definitions for the pulse peak detector: filter sample width,
// default timestamp width and the detector state encoding.
package pulse_peak_detector_pkg;

   localparam int SIZE_FILTER_DATA = 16;
   localparam int TS_W_DEFAULT     = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RISE,
      ST_HOLDOFF
   } state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/pulse_peak_detector.sv
// Detects above-threshold pulses on the signed filter stream and emits one
// {amplitude, timestamp, pile-up} event per pulse through a one-entry slot.
module pulse_peak_detector
   import pulse_peak_detector_pkg::*;
#(
   parameter int TS_W      = TS_W_DEFAULT,
   parameter int MAX_WIDTH = 64,
   parameter int HOLDOFF   = 16
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic [SIZE_FILTER_DATA-1:0] filter_data,
   input  logic [SIZE_FILTER_DATA-1:0] threshold,
   output logic [SIZE_FILTER_DATA-1:0] peak_amp,
   output logic [TS_W-1:0]             peak_time,
   output logic                        peak_pileup,
   output logic                        peak_valid,
   input  logic                        peak_ready,
   output logic [7:0]                  lost_count,
   output logic                        busy
);

   localparam int WIDTH_W = $clog2(MAX_WIDTH + 1);
   localparam int HOLD_W  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   logic signed [SIZE_FILTER_DATA-1:0] x_q;
   logic signed [SIZE_FILTER_DATA-1:0] thr_s;
   logic signed [SIZE_FILTER_DATA-1:0] max_q;
   logic signed [SIZE_FILTER_DATA-1:0] max_d;
   logic [TS_W-1:0]                    ts_q;
   logic [TS_W-1:0]                    tmax_q;
   logic [TS_W-1:0]                    tmax_d;
   logic                               above_prev_q;
   state_t                             state_q;
   logic [WIDTH_W-1:0]                 width_q;
   logic [HOLD_W-1:0]                  hold_q;
   logic [SIZE_FILTER_DATA-1:0]        amp_q;
   logic [TS_W-1:0]                    time_q;
   logic                               pile_q;
   logic                               valid_q;
   logic [7:0]                         lost_q;

   logic above_thr;
   logic rise;
   logic close_fall;
   logic close_pile;
   logic close_evt;
   logic slot_free;

   assign thr_s     = threshold;
   assign above_thr = (x_q > thr_s);
   assign rise      = above_thr && !above_prev_q;

   // Strict greater-than keeps the first occurrence of a flat-top maximum.
   assign max_d  = (x_q > max_q) ? x_q  : max_q;
   assign tmax_d = (x_q > max_q) ? ts_q : tmax_q;

   assign close_fall = (state_q == ST_RISE) && !above_thr;
   assign close_pile = (state_q == ST_RISE) && above_thr &&
                       (width_q == WIDTH_W'(MAX_WIDTH));
   assign close_evt  = close_fall || close_pile;
   assign slot_free  = !valid_q || peak_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x_q          <= '0;
         ts_q         <= '0;
         above_prev_q <= 1'b1;
         state_q      <= ST_IDLE;
         max_q        <= '0;
         tmax_q       <= '0;
         width_q      <= '0;
         hold_q       <= '0;
         amp_q        <= '0;
         time_q       <= '0;
         pile_q       <= 1'b0;
         valid_q      <= 1'b0;
         lost_q       <= 8'd0;
      end else begin
         x_q          <= filter_data;
         ts_q         <= ts_q + 1'b1;
         above_prev_q <= above_thr;

         case (state_q)
            ST_IDLE: begin
               if (rise) begin
                  state_q <= ST_RISE;
                  max_q   <= x_q;
                  tmax_q  <= ts_q;
                  width_q <= WIDTH_W'(1);
               end
            end
            ST_RISE: begin
               max_q  <= max_d;
               tmax_q <= tmax_d;
               if (close_evt) begin
                  state_q <= ST_HOLDOFF;
                  hold_q  <= HOLD_W'(HOLDOFF - 1);
               end else begin
                  width_q <= width_q + 1'b1;
               end
            end
            ST_HOLDOFF: begin
               if (hold_q == '0) state_q <= ST_IDLE;
               else              hold_q  <= hold_q - 1'b1;
            end
            default: state_q <= ST_IDLE;
         endcase

         // A close landing on an accepted slot overwrites it in place.
         if (close_evt) begin
            if (slot_free) begin
               amp_q   <= max_d;
               time_q  <= tmax_d;
               pile_q  <= close_pile;
               valid_q <= 1'b1;
            end else begin
               lost_q  <= sat_inc8(lost_q);
            end
         end else if (valid_q && peak_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign peak_amp    = amp_q;
   assign peak_time   = time_q;
   assign peak_pileup = pile_q;
   assign peak_valid  = valid_q;
   assign lost_count  = lost_q;
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pulse_peak_detector.sv
// Directed bench for pulse_peak_detector: a vector table for a single pulse
// followed by hand-written sequences for the multi-cycle corner cases.
module tb_pulse_peak_detector;
   import pulse_peak_detector_pkg::*;

   localparam int W = SIZE_FILTER_DATA;
   localparam int HOLD = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  filter_data;
   logic [W-1:0]  threshold;
   logic [W-1:0]  peak_amp;
   logic [31:0]   peak_time;
   logic          peak_pileup;
   logic          peak_valid;
   logic          peak_ready;
   logic [7:0]    lost_count;
   logic          busy;

   int checks = 0;
   int errors = 0;
   int edge_cnt = 0;

   pulse_peak_detector #(.TS_W(32), .MAX_WIDTH(8), .HOLDOFF(HOLD)) dut (
      .clk         (clk),
      .reset       (reset),
      .filter_data (filter_data),
      .threshold   (threshold),
      .peak_amp    (peak_amp),
      .peak_time   (peak_time),
      .peak_pileup (peak_pileup),
      .peak_valid  (peak_valid),
      .peak_ready  (peak_ready),
      .lost_count  (lost_count),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int   data;
      logic rdy;
      logic exp_valid;
      logic exp_busy;
      logic chk_ev;
      int   exp_amp;
      int   exp_time;
      logic exp_pile;
   } vec_t;

   vec_t tbl [25];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", nm, act, exp);
      end
   endtask

   task automatic step(input int d, input logic r);
      filter_data = W'(d);
      peak_ready  = r;
      @(posedge clk);
      #1;
      edge_cnt++;
   endtask

   task automatic zeros(input int n, input int d);
      for (int i = 0; i < n; i++) step(d, 1'b0);
   endtask

   task automatic setrow(input int i, input int d, input logic r, input logic v,
                         input logic b, input logic ev, input int amp, input int t,
                         input logic p);
      tbl[i].data = d;       tbl[i].rdy = r;
      tbl[i].exp_valid = v;  tbl[i].exp_busy = b;
      tbl[i].chk_ev = ev;    tbl[i].exp_amp = amp;
      tbl[i].exp_time = t;   tbl[i].exp_pile = p;
   endtask

   task automatic chk_event(input string nm, input int amp, input int t, input logic p);
      chk({nm, "_valid"},  int'(peak_valid), 1);
      chk({nm, "_amp"},    int'($signed(peak_amp)), amp);
      chk({nm, "_time"},   int'(peak_time), t);
      chk({nm, "_pileup"}, int'(peak_pileup), int'(p));
   endtask

   int t_ev;
   int lost_base;

   initial begin
      // Single pulse: sample in row i is presented before edge i+1, so its ts is i+1.
      setrow(0, 0,   0, 0, 0, 0, 0, 0, 0);
      setrow(1, 50,  0, 0, 0, 0, 0, 0, 0);
      setrow(2, 150, 0, 0, 0, 0, 0, 0, 0);
      setrow(3, 300, 0, 0, 1, 0, 0, 0, 0);
      setrow(4, 250, 0, 0, 1, 0, 0, 0, 0);
      setrow(5, 90,  0, 0, 1, 0, 0, 0, 0);
      setrow(6, 0,   0, 1, 1, 1, 300, 4, 0);
      setrow(7, 0,   0, 1, 1, 1, 300, 4, 0);
      setrow(8, 0,   1, 0, 1, 0, 0, 0, 0);
      for (int i = 9; i <= 21; i++) setrow(i, 0, 0, 0, 1, 0, 0, 0, 0);
      for (int i = 22; i <= 24; i++) setrow(i, 0, 0, 0, 0, 0, 0, 0, 0);

      reset       = 1'b1;
      filter_data = '0;
      threshold   = W'(100);
      peak_ready  = 1'b0;
      #1 reset = 1'b0;
      #2;
      chk("rst_amp",   int'(peak_amp), 0);
      chk("rst_time",  int'(peak_time), 0);
      chk("rst_pile",  int'(peak_pileup), 0);
      chk("rst_valid", int'(peak_valid), 0);
      chk("rst_lost",  int'(lost_count), 0);
      chk("rst_busy",  int'(busy), 0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      edge_cnt = 0;

      for (int i = 0; i < 25; i++) begin
         step(tbl[i].data, tbl[i].rdy);
         chk($sformatf("tbl%0d_valid", i), int'(peak_valid), int'(tbl[i].exp_valid));
         chk($sformatf("tbl%0d_busy", i),  int'(busy), int'(tbl[i].exp_busy));
         if (tbl[i].chk_ev) begin
            chk($sformatf("tbl%0d_amp", i),  int'($signed(peak_amp)), tbl[i].exp_amp);
            chk($sformatf("tbl%0d_time", i), int'(peak_time), tbl[i].exp_time);
            chk($sformatf("tbl%0d_pile", i), int'(peak_pileup), int'(tbl[i].exp_pile));
         end
      end

      // Flat top: the first of the equal maxima provides the timestamp.
      step(150, 0);
      t_ev = edge_cnt + 1;
      step(200, 0); step(200, 0); step(200, 0); step(50, 0); step(0, 0);
      chk_event("flat", 200, t_ev, 1'b0);
      step(0, 1);
      chk("flat_acc_valid", int'(peak_valid), 0);
      zeros(18, 0);

      // Pile-up: held high input closes once at MAX_WIDTH, no retrigger while high.
      t_ev = edge_cnt + 1;
      for (int i = 0; i < 40; i++) step(500, 0);
      chk_event("pile", 500, t_ev, 1'b1);
      chk("pile_lost", int'(lost_count), 0);
      chk("pile_busy", int'(busy), 0);
      step(500, 1);
      chk("pile_acc_valid", int'(peak_valid), 0);
      step(500, 0); step(500, 0);
      chk("pile_noretrig_busy", int'(busy), 0);
      chk("pile_noretrig_valid", int'(peak_valid), 0);
      step(0, 0); step(0, 0);
      t_ev = edge_cnt + 1;
      step(300, 0); step(0, 0); step(0, 0);
      chk_event("retrig", 300, t_ev, 1'b0);
      step(0, 1);
      zeros(18, 0);

      // Backpressure: three pulses with the slot never drained.
      lost_base = int'(lost_count);
      t_ev = edge_cnt + 1;
      step(200, 0); step(0, 0); zeros(HOLD + 5, 0);
      step(250, 0); step(0, 0); zeros(HOLD + 5, 0);
      step(260, 0); step(0, 0); zeros(HOLD + 5, 0);
      chk_event("bp", 200, t_ev, 1'b0);
      chk("bp_lost", int'(lost_count), lost_base + 2);
      step(0, 1);
      chk("bp_acc_valid", int'(peak_valid), 0);

      // Accept and load in the same cycle.
      step(220, 0); step(0, 0); zeros(18, 0);
      chk("al_pending_amp", int'($signed(peak_amp)), 220);
      lost_base = int'(lost_count);
      t_ev = edge_cnt + 1;
      step(400, 0); step(0, 0); step(0, 1);
      chk_event("al_new", 400, t_ev, 1'b0);
      chk("al_lost", int'(lost_count), lost_base);
      step(0, 0);
      chk("al_hold_valid", int'(peak_valid), 1);
      chk("al_hold_amp", int'($signed(peak_amp)), 400);
      step(0, 1);
      chk("al_acc_valid", int'(peak_valid), 0);
      zeros(18, 0);

      // Negative samples against a negative threshold.
      step(-100, 0); step(-100, 0);
      threshold = W'(-50);
      step(-100, 0); step(-100, 0); step(-20, 0);
      t_ev = edge_cnt + 1;
      step(-10, 0); step(-60, 0); step(-100, 0);
      chk_event("neg", -10, t_ev, 1'b0);
      zeros(18, -100);

      // Reset during RISE with an event still pending.
      step(-20, 0); step(-10, 0);
      chk("rst_mid_busy_before", int'(busy), 1);
      chk("rst_mid_valid_before", int'(peak_valid), 1);
      reset = 1'b0;
      #2;
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_valid", int'(peak_valid), 0);
      chk("rst_mid_lost", int'(lost_count), 0);
      reset = 1'b1;
      zeros(20, -100);
      chk("post_rst_valid", int'(peak_valid), 0);
      chk("post_rst_busy", int'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pulse_peak_detector.md
# pulse_peak_detector

Downstream consumer of the trapezoidal shaping filter output. It watches the signed filtered stream sample by sample and detects pulses that rise above a programmable threshold. For each pulse it captures the maximum amplitude and a free-running timestamp of that maximum. It delivers one event per pulse to the readout logic over a valid/ready handshake, with pile-up flagging and a saturating lost-event counter.

## Interface
Parameters:
- SIZE_FILTER_DATA, from shared package: width of the filter output sample, treated as two's-complement signed.
- TS_W, 32: timestamp counter width.
- MAX_WIDTH, 64: maximum cycles a pulse may stay above threshold before it is force-closed as pile-up.
- HOLDOFF, 16: dead-time cycles after each event.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- filter_data  in  SIZE_FILTER_DATA  signed filter sample, one new value every clk.
- threshold  in  SIZE_FILTER_DATA  signed trigger level, quasi-static.
- peak_amp  out  SIZE_FILTER_DATA  signed maximum of the pulse.
- peak_time  out  TS_W  timestamp of the first occurrence of that maximum.
- peak_pileup  out  1  pulse closed by MAX_WIDTH rather than by falling below threshold.
- peak_valid  out  1  event available.
- peak_ready  in  1  consumer accepts the event.
- lost_count  out  8  saturating count of events dropped because the output slot was full.
- busy  out  1  FSM not in IDLE.

## Operation
- Input register: x <= filter_data every clk. All comparisons use x, signed.
- Timestamp: ts increments every clk and wraps modulo 2^TS_W. The ts value coincident with x is that sample's time.
- Armed flag: above_prev <= (x > threshold). A trigger requires a rising crossing: x > threshold while above_prev = 0.
- FSM states:
  - IDLE: on a rising crossing, go to RISE. Set max <= x, tmax <= ts, width <= 1.
  - RISE:
    - If x > max: max <= x, tmax <= ts. Equal values do not update, so the first occurrence wins.
    - If x <= threshold: close the event with pileup = 0.
    - Else if width == MAX_WIDTH: close the event with pileup = 1.
    - Else width++.
  - HOLDOFF: count HOLDOFF cycles, then go to IDLE. Crossings during HOLDOFF are ignored.
- Close event: if the output slot is free (peak_valid == 0, or peak_ready == 1 in the same cycle), load peak_amp/peak_time/peak_pileup and set peak_valid. Otherwise drop the event and increment lost_count, which saturates at 255. The FSM goes to HOLDOFF in both cases.
- Output handshake:
  - peak_valid stays high and all peak_* outputs stay stable until a cycle with peak_valid && peak_ready.
  - On accept with no new load, peak_valid clears.
  - Accept and load in the same cycle: the new event replaces the old one and peak_valid stays 1.
- After a pile-up close, no retrigger happens until x has fallen to or below threshold and then risen again.
- Threshold is sampled combinationally each cycle. Changing it mid-pulse affects only later comparisons.

## Timing
- Reset (asynchronous, active-low) values:
  - Outputs: peak_amp 0, peak_time 0, peak_pileup 0, peak_valid 0, lost_count 0, busy 0.
  - Internal: x 0, ts 0, above_prev 1 (prevents a false trigger on the first sample), state IDLE.
- Reset mid-pulse discards the pulse and any pending event.
- Latency: filter_data value before edge k is in x after edge k.
  - A closing sample presented before edge k gives peak_valid = 1 after edge k+1 (2 clocks).
  - A trigger sample presented before edge k gives busy = 1 after edge k+1.
- Dead time: from the close edge to IDLE is exactly HOLDOFF cycles.
  - Minimum event spacing is therefore 1 + HOLDOFF + 1 cycles.
- ts wraps silently. peak_time is the raw wrapped value.

## Structure
- Shared package: SIZE_FILTER_DATA (common with the shaping filter), TS_W default, and the state typedef enum {IDLE, RISE, HOLDOFF}.
- Single module. No sub-module is needed; the output slot is a one-entry register inside this module.

## Test plan
- Single pulse: threshold 100; samples 0,50,150,300,250,90,0; ts of the 300 sample = T.
  - Expect one event: amp 300, time T, pileup 0.
  - peak_valid rises 2 clocks after the 90 is presented.
- Flat top: samples 150,200,200,200,50.
  - Expect amp 200, time = ts of the first 200.
- Pile-up: MAX_WIDTH 8, input held at 500 for 20 cycles, threshold 100.
  - Expect exactly one event with pileup 1.
  - No second event until the input drops to 0 and rises again.
- Backpressure: peak_ready 0, three pulses separated by HOLDOFF+5 cycles.
  - First event is held stable; lost_count = 2.
  - Raising peak_ready clears peak_valid next clock.
- Accept/load same cycle: new close coincides with peak_ready = 1 on a pending event.
  - peak_valid stays 1, outputs show the new event, lost_count unchanged.
- Negative values and reset:
  - threshold -50 with samples -100,-20,-10,-60 gives amp -10.
  - Asserting reset during RISE gives busy 0 and peak_valid 0; no event is emitted.
